// File: rtl/pipe_backbone_pkg.sv
// =============================================================================
// pipe_backbone_pkg : stage metadata type and forwarding priority encoder
// Revision: 1.0
// =============================================================================
`default_nettype none

package pipe_backbone_pkg;

    localparam int MAX_STAGES    = 31;
    localparam int FWD_MAX_W     = $clog2(MAX_STAGES + 1);
    localparam int RD_ADDR_MAX_W = 16;

    typedef struct packed {
        logic                     valid;
        logic                     reg_we;
        logic [RD_ADDR_MAX_W-1:0] rd_addr;
    } stage_meta_t;

    // Returns index+1 of the lowest (youngest) set hit bit, 0 when none.
    function automatic logic [FWD_MAX_W-1:0] fwd_sel_f(input logic [MAX_STAGES-1:0] hit);
        fwd_sel_f = '0;
        for (int k = MAX_STAGES - 1; k >= 0; k--) begin
            if (hit[k]) fwd_sel_f = FWD_MAX_W'(k + 1);
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// =============================================================================
// pipe_stage_reg : one pipeline stage register with load / clear / hold
// Revision: 1.0
// =============================================================================
`default_nettype none

module pipe_stage_reg
    import pipe_backbone_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic              i_clk,
    input  logic              i_arst,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_data,
    input  stage_meta_t       i_meta,
    output logic [DATA_W-1:0] o_data,
    output stage_meta_t       o_meta
);

    logic [DATA_W-1:0] r_data;
    stage_meta_t       r_meta;

    // Clear only drops the valid bit; the stale payload is harmless once invalid.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_data <= '0;
            r_meta <= '0;
        end else if (i_load) begin
            r_data <= i_data;
            r_meta <= i_meta;
        end else if (i_clear) begin
            r_meta.valid <= 1'b0;
        end
    end

    assign o_data = r_data;
    assign o_meta = r_meta;

endmodule

`default_nettype wire

// File: rtl/pipe_backbone.sv
// =============================================================================
// pipe_backbone : N-stage in-order pipeline with stall/flush and forwarding
// Optional: define PIPE_PERF_CNT_EN for stall-cycle and flush counters
// Revision: 1.0
// =============================================================================
`default_nettype none

module pipe_backbone
    import pipe_backbone_pkg::*;
#(
    parameter int STAGES     = 4,
    parameter int DATA_W     = 64,
    parameter int REG_ADDR_W = 5,
    parameter int FWD_W      = $clog2(STAGES + 1)
) (
    input  logic                         i_clk,
    input  logic                         i_arst,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [DATA_W-1:0]            i_data,
    input  logic [REG_ADDR_W-1:0]        i_rd_addr,
    input  logic                         i_reg_we,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [DATA_W-1:0]            o_data,
    output logic [REG_ADDR_W-1:0]        o_rd_addr,
    output logic                         o_reg_we,
    input  logic [STAGES-1:0]            i_stall_mask,
    input  logic [STAGES-1:0]            i_flush_mask,
    input  logic [REG_ADDR_W-1:0]        i_rs1_addr,
    input  logic [REG_ADDR_W-1:0]        i_rs2_addr,
    output logic [FWD_W-1:0]             o_fwd_rs1,
    output logic [FWD_W-1:0]             o_fwd_rs2,
    output logic [STAGES-1:0]            o_stage_valid,
`ifdef PIPE_PERF_CNT_EN
    output logic [31:0]                  o_stall_cycles,
    output logic [31:0]                  o_flush_count,
`endif
    output logic [STAGES*REG_ADDR_W-1:0] o_stage_rd_addr
);

    logic [DATA_W-1:0]      w_data [STAGES];
    stage_meta_t            w_meta [STAGES];
    logic [STAGES-1:0]      w_valid;
    logic [STAGES-1:0]      w_eff_valid;
    logic [STAGES-1:0]      w_out_move;
    logic [STAGES-1:0]      w_accept;
    logic [STAGES-1:0]      w_src_ok;
    logic [STAGES-1:0]      w_load;
    logic [STAGES-1:0]      w_clear;
    logic [MAX_STAGES-1:0]  w_hit1;
    logic [MAX_STAGES-1:0]  w_hit2;
    logic                   w_next_accept;

    // A stage being flushed behaves as a bubble: its payload neither leaves nor blocks.
    assign w_eff_valid = w_valid & ~i_flush_mask;

    always_comb begin
        w_out_move    = '0;
        w_accept      = '0;
        w_next_accept = i_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_out_move[k] = w_eff_valid[k] & ~i_stall_mask[k] & w_next_accept;
            w_accept[k]   = ~i_stall_mask[k] & (~w_eff_valid[k] | w_out_move[k]);
            w_next_accept = w_accept[k];
        end
    end

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            logic [DATA_W-1:0] w_src_data;
            stage_meta_t       w_src_meta;

            if (k == 0) begin : g_head
                assign w_src_ok[k] = i_valid;
                assign w_src_data  = i_data;
                assign w_src_meta  = '{valid:   1'b1,
                                       reg_we:  i_reg_we,
                                       rd_addr: RD_ADDR_MAX_W'(i_rd_addr)};
            end else begin : g_body
                assign w_src_ok[k] = w_eff_valid[k-1] & ~i_stall_mask[k-1];
                assign w_src_data  = w_data[k-1];
                assign w_src_meta  = w_meta[k-1];
            end

            assign w_load[k]  = w_accept[k] & w_src_ok[k] & ~i_flush_mask[k];
            assign w_clear[k] = i_flush_mask[k] | (w_out_move[k] & ~w_load[k]);

            pipe_stage_reg #(
                .DATA_W (DATA_W)
            ) u_stage (
                .i_clk   (i_clk),
                .i_arst  (i_arst),
                .i_load  (w_load[k]),
                .i_clear (w_clear[k]),
                .i_data  (w_src_data),
                .i_meta  (w_src_meta),
                .o_data  (w_data[k]),
                .o_meta  (w_meta[k])
            );

            assign w_valid[k] = w_meta[k].valid;
            assign o_stage_rd_addr[k*REG_ADDR_W +: REG_ADDR_W] = w_meta[k].rd_addr[REG_ADDR_W-1:0];
        end
    endgenerate

    always_comb begin
        w_hit1 = '0;
        w_hit2 = '0;
        for (int s = 0; s < STAGES; s++) begin
            w_hit1[s] = w_meta[s].valid & w_meta[s].reg_we & (i_rs1_addr != '0) &
                        (w_meta[s].rd_addr == RD_ADDR_MAX_W'(i_rs1_addr));
            w_hit2[s] = w_meta[s].valid & w_meta[s].reg_we & (i_rs2_addr != '0) &
                        (w_meta[s].rd_addr == RD_ADDR_MAX_W'(i_rs2_addr));
        end
    end

    assign o_fwd_rs1     = FWD_W'(fwd_sel_f(w_hit1));
    assign o_fwd_rs2     = FWD_W'(fwd_sel_f(w_hit2));
    assign o_ready       = w_accept[0];
    assign o_valid       = w_valid[STAGES-1];
    assign o_data        = w_data[STAGES-1];
    assign o_rd_addr     = o_stage_rd_addr[(STAGES-1)*REG_ADDR_W +: REG_ADDR_W];
    assign o_reg_we      = w_valid[STAGES-1] & w_meta[STAGES-1].reg_we;
    assign o_stage_valid = w_valid;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;
    logic [32:0] w_flush_sum;

    assign w_flush_sum = {1'b0, r_flush_count} + 33'($countones(w_valid & i_flush_mask));

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (i_valid && !w_accept[0] && (r_stall_cycles != '1))
                r_stall_cycles <= r_stall_cycles + 32'd1;
            r_flush_count <= w_flush_sum[32] ? '1 : w_flush_sum[31:0];
        end
    end

    assign o_stall_cycles = r_stall_cycles;
    assign o_flush_count  = r_flush_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_backbone.sv
// =============================================================================
// tb_pipe_backbone : self-checking bench for pipe_backbone (STAGES=4)
// Revision: 1.0
// =============================================================================
`default_nettype none

module tb_pipe_backbone;

    localparam int STAGES = 4;
    localparam int DW     = 64;
    localparam int AW     = 5;
    localparam int FW     = 3;

    logic              clk;
    logic              i_arst;
    logic              i_valid;
    logic              o_ready;
    logic [DW-1:0]     i_data;
    logic [AW-1:0]     i_rd_addr;
    logic              i_reg_we;
    logic              o_valid;
    logic              i_ready;
    logic [DW-1:0]     o_data;
    logic [AW-1:0]     o_rd_addr;
    logic              o_reg_we;
    logic [STAGES-1:0] i_stall_mask;
    logic [STAGES-1:0] i_flush_mask;
    logic [AW-1:0]     i_rs1_addr;
    logic [AW-1:0]     i_rs2_addr;
    logic [FW-1:0]     o_fwd_rs1;
    logic [FW-1:0]     o_fwd_rs2;
    logic [STAGES-1:0] o_stage_valid;
    logic [STAGES*AW-1:0] o_stage_rd_addr;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0]       o_stall_cycles;
    logic [31:0]       o_flush_count;
`endif

    pipe_backbone #(.STAGES(STAGES), .DATA_W(DW), .REG_ADDR_W(AW)) dut (
        .i_clk           (clk),
        .i_arst          (i_arst),
        .i_valid         (i_valid),
        .o_ready         (o_ready),
        .i_data          (i_data),
        .i_rd_addr       (i_rd_addr),
        .i_reg_we        (i_reg_we),
        .o_valid         (o_valid),
        .i_ready         (i_ready),
        .o_data          (o_data),
        .o_rd_addr       (o_rd_addr),
        .o_reg_we        (o_reg_we),
        .i_stall_mask    (i_stall_mask),
        .i_flush_mask    (i_flush_mask),
        .i_rs1_addr      (i_rs1_addr),
        .i_rs2_addr      (i_rs2_addr),
        .o_fwd_rs1       (o_fwd_rs1),
        .o_fwd_rs2       (o_fwd_rs2),
        .o_stage_valid   (o_stage_valid),
`ifdef PIPE_PERF_CNT_EN
        .o_stall_cycles  (o_stall_cycles),
        .o_flush_count   (o_flush_count),
`endif
        .o_stage_rd_addr (o_stage_rd_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [DW-1:0] data;
        logic [AW-1:0] rd;
        logic          we;
    } sb_item_t;

    sb_item_t sb_q[$];
    logic     sb_en = 1'b0;
    int       n_out = 0;

    typedef struct {
        logic          vld;
        logic [DW-1:0] data;
        logic [AW-1:0] rd;
        logic          we;
        logic          rdy;
        logic [3:0]    stall;
        logic [3:0]    flush;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic          e_ready;
        logic          e_valid;
        logic [3:0]    e_sv;
        logic [FW-1:0] e_f1;
        logic [FW-1:0] e_f2;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Output-side handshake pops the scoreboard; input-side handshake pushes it.
    always @(negedge clk) begin
        if (sb_en && !i_arst) begin
            if (o_valid && i_ready && !i_stall_mask[STAGES-1]) begin
                n_out++;
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_underflow: got data %0h expected none", o_data);
                end else begin
                    sb_item_t e;
                    e = sb_q.pop_front();
                    if (o_data !== e.data || o_rd_addr !== e.rd || o_reg_we !== e.we) begin
                        errors++;
                        $display("FAIL sb_out: got %0h/%0d/%0b expected %0h/%0d/%0b",
                                 o_data, o_rd_addr, o_reg_we, e.data, e.rd, e.we);
                    end
                end
            end
            if (i_valid && o_ready && !i_flush_mask[0])
                sb_q.push_back('{i_data, i_rd_addr, i_reg_we});
        end
    end

    task automatic idle_inputs();
        i_valid = 1'b0; i_data = '0; i_rd_addr = '0; i_reg_we = 1'b0;
        i_ready = 1'b0; i_stall_mask = '0; i_flush_mask = '0;
        i_rs1_addr = '0; i_rs2_addr = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] outs[$];
        logic [DW-1:0] fl_words[4];
        int first_acc, first_out, ready_drops, acc, n0;

        idle_inputs();
        i_arst = 1'b1;
        repeat (2) @(posedge clk);
        #1 i_arst = 1'b0;

        // Reset state
        chk("rst_o_valid", DW'(o_valid), DW'(1'b0));
        chk("rst_o_ready", DW'(o_ready), DW'(1'b1));
        chk("rst_fwd1", DW'(o_fwd_rs1), '0);
        chk("rst_fwd2", DW'(o_fwd_rs2), '0);
        chk("rst_reg_we", DW'(o_reg_we), '0);
        chk("rst_stage_valid", DW'(o_stage_valid), '0);
`ifdef PIPE_PERF_CNT_EN
        chk("rst_stall_cnt", DW'(o_stall_cycles), '0);
        chk("rst_flush_cnt", DW'(o_flush_count), '0);
`endif
        sb_en = 1'b1;

        // Streaming at full throughput: 0x1..0x8
        first_acc = -1; first_out = -1; ready_drops = 0; n0 = n_out;
        for (int c = 0; c < 16; c++) begin
            i_valid = (c < 8); i_data = DW'(c + 1); i_rd_addr = AW'(c + 1);
            i_reg_we = 1'b1; i_ready = 1'b1;
            @(negedge clk);
            if (i_valid && o_ready && first_acc < 0) first_acc = c;
            if (o_valid && first_out < 0) first_out = c;
            if (c < 8 && !o_ready) ready_drops++;
            next_cycle();
        end
        chk("stream_ready_drops", DW'(ready_drops), '0);
        chk("stream_latency", DW'(first_out - first_acc), DW'(STAGES));
        chk("stream_count", DW'(n_out - n0), DW'(8));

        // Fill with consumer blocked, then drain
        idle_inputs();
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            i_valid = 1'b1; i_data = DW'(32'h100 + c); i_rd_addr = AW'(c + 2); i_reg_we = 1'b1;
            @(negedge clk);
            if (o_ready) acc++;
            next_cycle();
        end
        chk("fill_accepts", DW'(acc), DW'(STAGES));
        chk("fill_ready_low", DW'(o_ready), '0);
        idle_inputs();
        i_ready = 1'b1; n0 = n_out;
        repeat (8) next_cycle();
        chk("drain_count", DW'(n_out - n0), DW'(STAGES));
        chk("drain_sb_empty", DW'(sb_q.size()), '0);

        // Table: bubble collapse under an output stall plus forwarding selects
        //            vld   data      rd     we    rdy   stall    flush  rs1    rs2  | rdy   vld   sv       f1     f2
        tbl[0]  = '{1'b1, 64'hA0, 5'd5, 1'b1, 1'b0, 4'b0000, 4'b0, 5'd5, 5'd0, 1'b1, 1'b0, 4'b0000, 3'd0, 3'd0};
        tbl[1]  = '{1'b0, 64'h0,  5'd0, 1'b0, 1'b0, 4'b0000, 4'b0, 5'd5, 5'd5, 1'b1, 1'b0, 4'b0001, 3'd1, 3'd1};
        tbl[2]  = '{1'b0, 64'h0,  5'd0, 1'b0, 1'b0, 4'b0000, 4'b0, 5'd5, 5'd7, 1'b1, 1'b0, 4'b0010, 3'd2, 3'd0};
        tbl[3]  = '{1'b0, 64'h0,  5'd0, 1'b0, 1'b0, 4'b0000, 4'b0, 5'd5, 5'd0, 1'b1, 1'b0, 4'b0100, 3'd3, 3'd0};
        tbl[4]  = '{1'b1, 64'hB0, 5'd7, 1'b1, 1'b0, 4'b0000, 4'b0, 5'd5, 5'd7, 1'b1, 1'b1, 4'b1000, 3'd4, 3'd0};
        tbl[5]  = '{1'b1, 64'hC0, 5'd5, 1'b1, 1'b1, 4'b1000, 4'b0, 5'd5, 5'd7, 1'b1, 1'b1, 4'b1001, 3'd4, 3'd1};
        tbl[6]  = '{1'b1, 64'hD0, 5'd0, 1'b1, 1'b1, 4'b1000, 4'b0, 5'd5, 5'd7, 1'b1, 1'b1, 4'b1011, 3'd1, 3'd2};
        tbl[7]  = '{1'b1, 64'hE0, 5'd9, 1'b0, 1'b1, 4'b1000, 4'b0, 5'd0, 5'd5, 1'b0, 1'b1, 4'b1111, 3'd0, 3'd2};
        tbl[8]  = '{1'b1, 64'hE0, 5'd9, 1'b0, 1'b1, 4'b0000, 4'b0, 5'd9, 5'd7, 1'b1, 1'b1, 4'b1111, 3'd0, 3'd3};
        tbl[9]  = '{1'b0, 64'h0,  5'd0, 1'b0, 1'b1, 4'b0000, 4'b0, 5'd9, 5'd0, 1'b1, 1'b1, 4'b1111, 3'd0, 3'd0};
        tbl[10] = '{1'b0, 64'h0,  5'd0, 1'b0, 1'b0, 4'b0000, 4'b0, 5'd5, 5'd7, 1'b1, 1'b1, 4'b1110, 3'd4, 3'd0};
        tbl[11] = '{1'b0, 64'h0,  5'd0, 1'b0, 1'b1, 4'b0000, 4'b0, 5'd0, 5'd0, 1'b1, 1'b1, 4'b1110, 3'd0, 3'd0};
        tbl[12] = '{1'b0, 64'h0,  5'd0, 1'b0, 1'b1, 4'b0000, 4'b0, 5'd0, 5'd0, 1'b1, 1'b1, 4'b1100, 3'd0, 3'd0};
        tbl[13] = '{1'b0, 64'h0,  5'd0, 1'b0, 1'b1, 4'b0000, 4'b0, 5'd0, 5'd0, 1'b1, 1'b1, 4'b1000, 3'd0, 3'd0};
        for (int i = 0; i < 14; i++) begin
            i_valid = tbl[i].vld; i_data = tbl[i].data; i_rd_addr = tbl[i].rd;
            i_reg_we = tbl[i].we; i_ready = tbl[i].rdy; i_stall_mask = tbl[i].stall;
            i_flush_mask = tbl[i].flush; i_rs1_addr = tbl[i].rs1; i_rs2_addr = tbl[i].rs2;
            @(negedge clk);
            chk($sformatf("tbl%0d_ready", i), DW'(o_ready), DW'(tbl[i].e_ready));
            chk($sformatf("tbl%0d_valid", i), DW'(o_valid), DW'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_sv", i), DW'(o_stage_valid), DW'(tbl[i].e_sv));
            chk($sformatf("tbl%0d_fwd1", i), DW'(o_fwd_rs1), DW'(tbl[i].e_f1));
            chk($sformatf("tbl%0d_fwd2", i), DW'(o_fwd_rs2), DW'(tbl[i].e_f2));
            next_cycle();
        end
        idle_inputs();
        chk("tbl_sb_empty", DW'(sb_q.size()), '0);
        chk("tbl_pipe_empty", DW'(o_stage_valid), '0);

        // Flush stages 0 and 1 while holding A,B,C,D (D oldest)
        sb_en = 1'b0;
        fl_words[0] = 64'hD4; fl_words[1] = 64'hC3; fl_words[2] = 64'hB2; fl_words[3] = 64'hA1;
        for (int i = 0; i < 4; i++) begin
            i_valid = 1'b1; i_data = fl_words[i];
            next_cycle();
        end
        idle_inputs();
        chk("flush_full", DW'(o_stage_valid), DW'(4'b1111));
        i_ready = 1'b1; i_flush_mask = 4'b0011;
        @(negedge clk);
        if (o_valid) outs.push_back(o_data);
        next_cycle();
        i_flush_mask = '0;
        chk("flush_sv_after", DW'(o_stage_valid), DW'(4'b1000));
`ifdef PIPE_PERF_CNT_EN
        chk("flush_cnt", DW'(o_flush_count), DW'(2));
`endif
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (o_valid && i_ready) outs.push_back(o_data);
            next_cycle();
        end
        chk("flush_out_count", DW'(outs.size()), DW'(2));
        if (outs.size() == 2) begin
            chk("flush_out0", outs[0], 64'hD4);
            chk("flush_out1", outs[1], 64'hC3);
        end

        // Asynchronous reset with three valid stages
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            i_valid = 1'b1; i_data = DW'(32'h300 + i);
            next_cycle();
        end
        idle_inputs();
        chk("arst_pre_sv", DW'(o_stage_valid), DW'(4'b0111));
        #2 i_arst = 1'b1;
        #1;
        chk("arst_o_valid", DW'(o_valid), '0);
        chk("arst_sv", DW'(o_stage_valid), '0);
        chk("arst_o_ready", DW'(o_ready), DW'(1'b1));
`ifdef PIPE_PERF_CNT_EN
        chk("arst_stall_cnt", DW'(o_stall_cycles), '0);
        chk("arst_flush_cnt", DW'(o_flush_count), '0);
`endif
        next_cycle();
        i_arst = 1'b0;
        next_cycle();
        chk("arst_post_sv", DW'(o_stage_valid), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
